// File: rtl/mul_div_unit.sv
// Multi-cycle unsigned multiply/divide unit feeding register-bank write-back.
// Shift-add multiply and restoring divide, one iteration per cycle, one op in flight.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic [4:0]       dest,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       result_reg,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [1:0]       op_q;
  logic [4:0]       dest_q;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] divisor;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_next;
  logic [WIDTH:0]     rem_shift;
  logic               div_keep;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;
  logic [WIDTH-1:0]   res_sel;

  // The kept difference is always below the divisor, so the low WIDTH bits of
  // the subtraction are exact even though the shifted remainder is WIDTH+1 wide.
  always_comb begin
    mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
    prod_next = prod[0] ? {mul_sum, prod[WIDTH-1:1]} : {1'b0, prod[2*WIDTH-1:1]};
    rem_shift = {rem, quo[WIDTH-1]};
    div_keep  = (rem_shift >= {1'b0, divisor});
    rem_next  = div_keep ? (rem_shift[WIDTH-1:0] - divisor) : rem_shift[WIDTH-1:0];
    quo_next  = {quo[WIDTH-2:0], div_keep};
    case (op_q)
      2'b00:   res_sel = prod[WIDTH-1:0];
      2'b01:   res_sel = prod[2*WIDTH-1:WIDTH];
      2'b10:   res_sel = quo;
      default: res_sel = rem;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      result_reg  <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      op_q        <= '0;
      dest_q      <= '0;
      mcand       <= '0;
      divisor     <= '0;
      prod        <= '0;
      rem         <= '0;
      quo         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            op_q    <= op;
            dest_q  <= dest;
            mcand   <= rs_val;
            divisor <= rt_val;
            prod    <= {{WIDTH{1'b0}}, rt_val};
            rem     <= '0;
            quo     <= rs_val;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        // Counter runs 0..WIDTH-1 across the iterations; the extra RUN cycle
        // at LAST publishes the result so latency is WIDTH+1 from accept.
        RUN: begin
          if (cnt == LAST) begin
            result      <= res_sel;
            result_reg  <= dest_q;
            div_by_zero <= op_q[1] && (divisor == '0);
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= DONE;
          end else begin
            prod <= prod_next;
            rem  <= rem_next;
            quo  <= quo_next;
            cnt  <= cnt + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
